// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared length codes, FSM states and size helper for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Access size in bytes; the illegal code maps to zero.
    function automatic logic [2:0] len_size(input logic [1:0] len);
        logic [2:0] size;
        case (len)
            LEN_BYTE: size = 3'd1;
            LEN_HALF: size = 3'd2;
            LEN_WORD: size = 3'd4;
            default:  size = 3'd0;
        endcase
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response handshake bundle between the load/store
//               unit (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  MEM_length;
    logic        MEM_read_signed;
    logic [31:0] MEM_address;
    logic [31:0] MEM_write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] MEM_read_data;
    logic        resp_error;

    modport master (
        output req_valid, req_write, MEM_length, MEM_read_signed,
               MEM_address, MEM_write_data, resp_ready,
        input  req_ready, resp_valid, MEM_read_data, resp_error
    );

    modport slave (
        input  req_valid, req_write, MEM_length, MEM_read_signed,
               MEM_address, MEM_write_data, resp_ready,
        output req_ready, resp_valid, MEM_read_data, resp_error
    );

endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Byte-enable generation, store lane replication and load
//               extraction/extension for little-endian sub-word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  wire logic [1:0]  offset_i,
    input  wire logic [1:0]  length_i,
    input  wire logic        signed_i,
    input  wire logic [31:0] store_data_i,
    input  wire logic [31:0] load_word_i,
    output logic      [3:0]  byte_en_o,
    output logic      [31:0] store_lanes_o,
    output logic      [31:0] load_data_o
);

    logic [31:0] w_shifted;

    // Bring the addressed byte/halfword down to bit 0 for extraction.
    assign w_shifted = load_word_i >> {offset_i, 3'b000};

    always_comb begin
        byte_en_o     = 4'b0000;
        store_lanes_o = 32'h0;
        load_data_o   = 32'h0;
        case (length_i)
            LEN_BYTE: begin
                byte_en_o     = 4'b0001 << offset_i;
                store_lanes_o = {4{store_data_i[7:0]}};
                load_data_o   = {{24{signed_i & w_shifted[7]}}, w_shifted[7:0]};
            end
            LEN_HALF: begin
                byte_en_o     = 4'b0011 << offset_i;
                store_lanes_o = {2{store_data_i[15:0]}};
                load_data_o   = {{16{signed_i & w_shifted[15]}}, w_shifted[15:0]};
            end
            LEN_WORD: begin
                byte_en_o     = 4'b1111;
                store_lanes_o = store_data_i;
                load_data_o   = load_word_i;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Latency-programmable data-memory responder with byte/half/
//               word little-endian access, extension and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int LATENCY   = 2
)(
    input  wire logic         SYS_clk,
    input  wire logic         SYS_reset,
    dmem_responder_if.slave   mem_if
);

    localparam int              c_aw       = $clog2(MEM_BYTES);
    localparam int              c_iw       = (c_aw > 2) ? c_aw - 2 : 1;
    localparam int              c_words    = MEM_BYTES / 4;
    localparam int              c_cw       = $clog2(LATENCY) + 1;
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(LATENCY - 1);
    localparam logic [32:0]     c_limit    = 33'(MEM_BYTES);

    state_e          state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            write_q, write_d;
    logic [1:0]      len_q, len_d;
    logic            signed_q, signed_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            error_q, error_d;

    logic [31:0]     mem_q [c_words];

    logic [c_iw-1:0] w_idx;
    logic [2:0]      w_size;
    logic [32:0]     w_end;
    logic            w_err;
    logic            w_access;
    logic            w_store;
    logic [3:0]      w_be;
    logic [31:0]     w_lanes;
    logic [31:0]     w_word;
    logic [31:0]     w_load;

    generate
        if (c_aw > 2) begin : g_idx_wide
            assign w_idx = addr_q[c_aw-1:2];
        end else begin : g_idx_single
            assign w_idx = '0;
        end
    endgenerate

    // End address is formed in 33 bits so requests near the top of the
    // address space are rejected rather than wrapping into range.
    assign w_size   = len_size(len_q);
    assign w_end    = {1'b0, addr_q} + {30'b0, w_size};
    assign w_err    = (len_q == LEN_NONE)
                    | ((len_q == LEN_HALF) & addr_q[0])
                    | ((len_q == LEN_WORD) & (addr_q[1:0] != 2'b00))
                    | (w_end > c_limit);
    assign w_access = (state_q == WAIT) && (cnt_q == '0);
    assign w_store  = w_access & write_q & ~w_err;
    assign w_word   = mem_q[w_idx];

    dmem_lane_align u_lane_align (
        .offset_i      (addr_q[1:0]),
        .length_i      (len_q),
        .signed_i      (signed_q),
        .store_data_i  (wdata_q),
        .load_word_i   (w_word),
        .byte_en_o     (w_be),
        .store_lanes_o (w_lanes),
        .load_data_o   (w_load)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        len_d    = len_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (mem_if.req_valid && req_ready_q) begin
                    write_d  = mem_if.req_write;
                    len_d    = mem_if.MEM_length;
                    signed_d = mem_if.MEM_read_signed;
                    addr_d   = mem_if.MEM_address;
                    wdata_d  = mem_if.MEM_write_data;
                    cnt_d    = c_cnt_init;
                    rdata_d  = 32'h0;
                    error_d  = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cw'(1);
                end else begin
                    error_d = w_err;
                    rdata_d = (w_err || write_q) ? 32'h0 : w_load;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_if.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so ready stays low through the reset edge itself.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            write_q     <= 1'b0;
            len_q       <= LEN_NONE;
            signed_q    <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            write_q     <= write_d;
            len_q       <= len_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    // Storage has no reset; a reset on the access edge suppresses the store.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset && w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

    assign mem_if.req_ready     = req_ready_q;
    assign mem_if.resp_valid    = (state_q == RESP);
    assign mem_if.MEM_read_data = rdata_q;
    assign mem_if.resp_error    = error_q;

endmodule
`default_nettype wire
